// File: rtl/serpent_xts_pkg.sv
// Shared definitions for the Serpent XTS sector sequencer.
//   xts_state_e   : FSM state encoding
//   KEY_SEL_*     : core key select values (K1 data key, K2 tweak key)
//   XTS_GF_POLY   : default GF(2^128) reduction constant for multiply-by-alpha
package serpent_xts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TWK_START = 3'd1,
    ST_TWK_WAIT  = 3'd2,
    ST_DIN       = 3'd3,
    ST_BLK_START = 3'd4,
    ST_BLK_WAIT  = 3'd5,
    ST_DOUT      = 3'd6,
    ST_DONE      = 3'd7
  } xts_state_e;

  localparam logic KEY_SEL_DATA  = 1'b0;
  localparam logic KEY_SEL_TWEAK = 1'b1;

  localparam logic [7:0] XTS_GF_POLY = 8'h87;

endpackage

// File: rtl/xts_gf_mulalpha.sv
// Combinational multiply-by-alpha in GF(2^128), XTS bit ordering
// (bit 0 = LSB of byte 0).
//   t_i : current tweak
//   t_o : t_i * alpha  (shift left, fold carry-out of bit 127 into [7:0])
module xts_gf_mulalpha #(
  parameter logic [7:0] GF_POLY = 8'h87
) (
  input  logic [127:0] t_i,
  output logic [127:0] t_o
);

  assign t_o = {t_i[126:0], 1'b0} ^ {120'd0, GF_POLY & {8{t_i[127]}}};

endmodule

// File: rtl/serpent_xts_ctrl.sv
// Sector-level XTS sequencer driving a single iterative Serpent core.
// Encrypts the sector tweak under K2 to form T0, then for each block sends
// (P ^ Tj) to the core under K1 and emits C = core_out ^ Tj, advancing
// Tj+1 = Tj * alpha. One core operation in flight at a time.
//   i_cmd_*   / o_cmd_ready  : sector command (tweak, block count)
//   i_din_*   / o_din_ready  : plaintext block stream
//   o_dout_*  / i_dout_ready : ciphertext block stream, o_blk_idx = j
//   o_core_*  / i_core_*     : core start/key select/input, done/result
//   o_busy, o_done           : status
module serpent_xts_ctrl
  import serpent_xts_pkg::*;
#(
  parameter int         BLK_CNT_W = 6,
  parameter logic [7:0] GF_POLY   = XTS_GF_POLY
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [127:0]         i_tweak,
  input  logic [BLK_CNT_W-1:0] i_blk_cnt,
  input  logic                 i_din_valid,
  output logic                 o_din_ready,
  input  logic [127:0]         i_din,
  output logic                 o_dout_valid,
  input  logic                 i_dout_ready,
  output logic [127:0]         o_dout,
  output logic [BLK_CNT_W-1:0] o_blk_idx,
  input  logic                 i_keys_ready,
  output logic                 o_core_start,
  output logic                 o_core_key_sel,
  output logic [127:0]         o_core_data,
  input  logic                 i_core_done,
  input  logic [127:0]         i_core_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [BLK_CNT_W-1:0] ONE = {{(BLK_CNT_W-1){1'b0}}, 1'b1};

  xts_state_e           state_q, state_d;
  logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [BLK_CNT_W-1:0] idx_q, idx_d;
  logic [127:0]         t_q, t_d;
  logic [127:0]         core_data_q, core_data_d;
  logic                 key_sel_q, key_sel_d;
  logic [127:0]         dout_q, dout_d;
  logic [127:0]         t_alpha;
  logic                 last_blk;

  xts_gf_mulalpha #(.GF_POLY(GF_POLY)) u_mulalpha (
    .t_i (t_q),
    .t_o (t_alpha)
  );

  assign last_blk = (idx_q == blk_cnt_q - ONE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (i_cmd_valid)
                      state_d = (i_blk_cnt == '0) ? ST_DONE : ST_TWK_START;
      ST_TWK_START: if (i_keys_ready) state_d = ST_TWK_WAIT;
      ST_TWK_WAIT:  if (i_core_done)  state_d = ST_DIN;
      ST_DIN:       if (i_din_valid)  state_d = ST_BLK_START;
      ST_BLK_START: if (i_keys_ready) state_d = ST_BLK_WAIT;
      ST_BLK_WAIT:  if (i_core_done)  state_d = ST_DOUT;
      ST_DOUT:      if (i_dout_ready) state_d = last_blk ? ST_DONE : ST_DIN;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; core start follows key readiness in the
  // same cycle so a key stall delays the pulse without an extra cycle.
  always_comb begin
    o_cmd_ready  = (state_q == ST_IDLE);
    o_din_ready  = (state_q == ST_DIN);
    o_dout_valid = (state_q == ST_DOUT);
    o_core_start = ((state_q == ST_TWK_START) || (state_q == ST_BLK_START)) && i_keys_ready;
    o_busy       = (state_q != ST_IDLE);
    o_done       = (state_q == ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    blk_cnt_d   = blk_cnt_q;
    idx_d       = idx_q;
    t_d         = t_q;
    core_data_d = core_data_q;
    key_sel_d   = key_sel_q;
    dout_d      = dout_q;
    unique case (state_q)
      ST_IDLE: if (i_cmd_valid) begin
        blk_cnt_d = i_blk_cnt;
        if (i_blk_cnt != '0) begin
          core_data_d = i_tweak;
          key_sel_d   = KEY_SEL_TWEAK;
        end
      end
      ST_TWK_WAIT: if (i_core_done) begin
        t_d   = i_core_data;
        idx_d = '0;
      end
      ST_DIN: if (i_din_valid) begin
        core_data_d = i_din ^ t_q;
        key_sel_d   = KEY_SEL_DATA;
      end
      // Output is whitened with the pre-update tweak; T advances on the same edge.
      ST_BLK_WAIT: if (i_core_done) begin
        dout_d = i_core_data ^ t_q;
        t_d    = t_alpha;
      end
      ST_DOUT: if (i_dout_ready && !last_blk) idx_d = idx_q + ONE;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blk_cnt_q   <= '0;
      idx_q       <= '0;
      t_q         <= '0;
      core_data_q <= '0;
      key_sel_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      idx_q       <= idx_d;
      t_q         <= t_d;
      core_data_q <= core_data_d;
      key_sel_q   <= key_sel_d;
      dout_q      <= dout_d;
    end
  end

  assign o_dout         = dout_q;
  assign o_blk_idx      = idx_q;
  assign o_core_data    = core_data_q;
  assign o_core_key_sel = key_sel_q;

endmodule

// File: doc/serpent_xts_ctrl.md
Name: serpent_xts_ctrl

Overview:
Sector-level XTS sequencer for the single iterative Serpent encryption core.
- Per sector command, encrypts the tweak with the tweak key to form T0.
- For each 128-bit data block, drives the core with (P xor Tj) under the data key, and emits C = core_out xor Tj.
- Advances Tj+1 = Tj * alpha in GF(2^128).
- Sits between the sector DMA/stream front end and the core plus key-schedule wrappers. Only one core operation is in flight at a time.

Parameters:
BLK_CNT_W, 6, width of block-count and block-index fields; up to 2^BLK_CNT_W - 1 blocks per sector.
GF_POLY, 8'h87, reduction constant XORed into bits [7:0] on carry-out of bit 127.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_cmd_valid  input  1  sector command valid.
o_cmd_ready  output  1  high only in IDLE.
i_tweak  input  128  sector tweak (plaintext form).
i_blk_cnt  input  BLK_CNT_W  number of data blocks in the sector.
i_din_valid  input  1  plaintext block valid.
o_din_ready  output  1  high only in DIN.
i_din  input  128  plaintext block.
o_dout_valid  output  1  ciphertext block valid.
i_dout_ready  input  1  downstream accepts.
o_dout  output  128  ciphertext block.
o_blk_idx  output  BLK_CNT_W  index j of the block being processed or output.
i_keys_ready  input  1  key schedule holds valid subkeys for both keys.
o_core_start  output  1  one-cycle start pulse to the core.
o_core_key_sel  output  1  0 = data key K1, 1 = tweak key K2; stable from start through done.
o_core_data  output  128  core input block; registered, stable from start through done.
i_core_done  input  1  one-cycle pulse; i_core_data is valid in that cycle.
i_core_data  input  128  core result.
o_busy  output  1  state != IDLE.
o_done  output  1  one-cycle pulse at sector completion.

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
  - All outputs 0, except o_cmd_ready = 1.
  - T register, block counter and o_dout cleared.
  - A core operation in flight is abandoned; i_core_done is ignored in IDLE.
- States: IDLE, TWK_START, TWK_WAIT, DIN, BLK_START, BLK_WAIT, DOUT, DONE.
- IDLE:
  - On i_cmd_valid and o_cmd_ready: latch i_blk_cnt, load o_core_data = i_tweak, set o_core_key_sel = 1, go to TWK_START.
  - If i_blk_cnt == 0: go straight to DONE instead, with no core activity.
- TWK_START / BLK_START:
  - Wait while i_keys_ready = 0.
  - When i_keys_ready = 1, assert o_core_start for exactly that cycle, then go to TWK_WAIT / BLK_WAIT.
- TWK_WAIT:
  - On i_core_done: T = i_core_data, block index = 0, go to DIN.
- DIN:
  - o_din_ready = 1.
  - On handshake: o_core_data = i_din xor T, o_core_key_sel = 0, go to BLK_START.
- BLK_WAIT:
  - On i_core_done: o_dout = i_core_data xor T, o_dout_valid = 1, go to DOUT.
  - In the same edge: T = mulalpha(T).
  - Note: o_dout uses the pre-update T.
- mulalpha(T):
  - T treated as a 128-bit integer, bit 0 = LSB of byte 0.
  - Result = (T << 1) with bit 0 = 0; if the old T[127] = 1, XOR GF_POLY into bits [7:0].
- DOUT:
  - o_dout and o_dout_valid are held stable until i_dout_ready.
  - On handshake, o_dout_valid drops next cycle.
  - If block index == blk_cnt - 1: go to DONE. Otherwise increment the block index and go to DIN.
- DONE: o_done = 1 for one cycle, then go to IDLE.
- i_core_done in any state other than TWK_WAIT or BLK_WAIT is ignored.
- Latency per block, with no stalls:
  - DIN handshake to o_core_start: 1 cycle.
  - i_core_done to o_dout_valid: 1 cycle.
  - DOUT handshake to o_din_ready: 1 cycle.
- The block counter never wraps: blk_cnt = 2^BLK_CNT_W - 1 is the maximum.

Decomposition:
- Shared package serpent_xts_pkg holds:
  - the state encoding constants;
  - KEY_SEL_DATA = 0 and KEY_SEL_TWEAK = 1;
  - GF_POLY.
- One natural sub-module: xts_gf_mulalpha, a combinational 128-bit multiply-by-alpha.
- Everything else is inline FSM plus registers.

Test Plan:
Stub core for all scenarios: result = rotl8(input), i.e. {in[119:0], in[127:120]}, with done 34 cycles after start regardless of key.
- Zero-block command (tweak = 128'h1, blk_cnt = 0): o_done pulses 1 cycle after acceptance; o_core_start never asserts.
- Carry-free sequence (tweak = 128'h1, blk_cnt = 2, din = 0, 0, downstream always ready):
  - o_dout = 128'h10100 at idx 0, then 128'h20200 at idx 1;
  - key_sel = 1 at the first start and 0 at the next two;
  - o_done pulses after the second output.
- Carry reduction (tweak = 128'h0080_0000_0000_0000_0000_0000_0000_0000, i.e. bit 119 set, blk_cnt = 2, din = 0, 0): T0 = bit 127 set; the second o_dout = 128'h8787.
- Backpressure (hold i_dout_ready = 0 for 10 cycles on block 0):
  - o_dout stays stable with o_dout_valid = 1;
  - o_din_ready stays 0 until the handshake.
- Key stall (i_keys_ready = 0 for 5 cycles after command accept): o_core_start is first asserted in the cycle i_keys_ready rises.
- Reset mid-operation (assert i_rst during BLK_WAIT of block 1):
  - outputs go to reset values immediately;
  - a following i_core_done is ignored;
  - a new command runs correctly from T0.
